// File: rtl/tdc_mux_delay_core.sv
// Delay-line TDC core: launch edge ripples through N mux/buffer taps, all taps captured and popcounted.
// Latency: taps/val_in at capture edge k appear on hw_o/val_out_o after edge k+N_SYNC+1.
// Backpressure: none; one sample per clock, val_out_o only tags the hw_o stream.
module tdc_mux_delay_core #(
  parameter int    N          = 64,
  parameter string DL_TYPE    = "DMUX",
  parameter int    N_SYNC     = 1,
  parameter string POP_METHOD = "SV"
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 val_in_i,
  input  logic                 pg_src_i,
  input  logic                 pg_bypass_i,
  input  logic                 pg_in_i,
  input  logic                 pg_tog_i,
  output logic [$clog2(N):0]   hw_o,
  output logic                 val_out_o
);

  localparam int HW_W = $clog2(N) + 1;

  // Reject unsupported configurations at elaboration time.
  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("tdc_mux_delay_core: N must be a power of two >= 2");
  end
  if (N_SYNC < 1) begin : g_bad_sync
    $error("tdc_mux_delay_core: N_SYNC must be >= 1");
  end
  if (DL_TYPE != "DMUX" && DL_TYPE != "BUF") begin : g_bad_dl
    $error("tdc_mux_delay_core: DL_TYPE must be DMUX or BUF");
  end
  if (POP_METHOD != "SV" && POP_METHOD != "TREE") begin : g_bad_pop
    $error("tdc_mux_delay_core: POP_METHOD must be SV or TREE");
  end

  // ---------------------------------------------------------------------------
  // Launch source
  // ---------------------------------------------------------------------------
  logic tog_q, tog_d;
  logic src;

  // Internal toggle source flips on request while enabled.
  always_comb begin
    tog_d = tog_q;
    if (en_i && pg_tog_i) tog_d = ~tog_q;
  end

  // Toggle source register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tog_q <= 1'b0;
    else         tog_q <= tog_d;
  end

  assign src = pg_src_i ? tog_q : pg_in_i;

  // Edge pulse generator: src XOR a 4-inverter delayed copy of itself gives a
  // narrow pulse per edge. The chain is kept so synthesis cannot fold it to 0.
  (* keep = "true", dont_touch = "true" *) logic pg_d0;
  (* keep = "true", dont_touch = "true" *) logic pg_d1;
  (* keep = "true", dont_touch = "true" *) logic pg_d2;
  (* keep = "true", dont_touch = "true" *) logic pg_d3;
  logic dl_in;

  assign pg_d0 = ~src;
  assign pg_d1 = ~pg_d0;
  assign pg_d2 = ~pg_d1;
  assign pg_d3 = ~pg_d2;
  assign dl_in = pg_bypass_i ? src : (src ^ pg_d3);

  // ---------------------------------------------------------------------------
  // Delay line: each stage is its own kept net so the chain is never collapsed.
  // ---------------------------------------------------------------------------
  logic [N-1:0] tap;

  for (genvar i = 0; i < N; i++) begin : g_dl
    (* keep = "true", dont_touch = "true" *) logic t;
    logic prev;
    if (i == 0) begin : g_first
      assign prev = dl_in;
    end else begin : g_next
      assign prev = g_dl[i-1].t;
    end
    if (DL_TYPE == "DMUX") begin : g_mux
      assign t = en_i ? prev : 1'b0;
    end else begin : g_buf
      assign t = prev & en_i;
    end
    assign tap[i] = t;
  end

  // ---------------------------------------------------------------------------
  // Capture and synchroniser; cap_q may go metastable, only sync output is used.
  // ---------------------------------------------------------------------------
  logic [N-1:0]      cap_q;
  logic              val_c_q;
  logic [N-1:0]      sync_q [N_SYNC];
  logic [N_SYNC-1:0] val_s_q;

  // Capture stage followed by N_SYNC synchroniser stages on taps and valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_q   <= '0;
      val_c_q <= 1'b0;
      val_s_q <= '0;
      for (int s = 0; s < N_SYNC; s++) sync_q[s] <= '0;
    end else begin
      cap_q      <= tap;
      val_c_q    <= val_in_i;
      sync_q[0]  <= cap_q;
      val_s_q[0] <= val_c_q;
      for (int s = 1; s < N_SYNC; s++) begin
        sync_q[s]  <= sync_q[s-1];
        val_s_q[s] <= val_s_q[s-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hamming weight of the last synchroniser stage
  // ---------------------------------------------------------------------------
  logic [HW_W-1:0] hw_d;
  logic [N-1:0]    pop_in;

  assign pop_in = sync_q[N_SYNC-1];

  if (POP_METHOD == "TREE") begin : g_pop_tree
    logic [HW_W-1:0] acc [N];
    // Pairwise adder tree reduced in place, one level per halving.
    always_comb begin
      for (int i = 0; i < N; i++) acc[i] = {{(HW_W-1){1'b0}}, pop_in[i]};
      for (int w = N / 2; w >= 1; w = w / 2) begin
        for (int j = 0; j < w; j++) acc[j] = acc[2*j] + acc[2*j+1];
      end
      hw_d = acc[0];
    end
  end else begin : g_pop_sv
    // Straight count-ones loop.
    always_comb begin
      hw_d = '0;
      for (int i = 0; i < N; i++) hw_d = hw_d + {{(HW_W-1){1'b0}}, pop_in[i]};
    end
  end

  logic [HW_W-1:0] hw_q;
  logic            val_out_q;

  // Output register: weight and its aligned valid tag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hw_q      <= '0;
      val_out_q <= 1'b0;
    end else begin
      hw_q      <= hw_d;
      val_out_q <= val_s_q[N_SYNC-1];
    end
  end

  assign hw_o      = hw_q;
  assign val_out_o = val_out_q;

endmodule

// File: tb/tb_tdc_mux_delay_core.sv
module tb_tdc_mux_delay_core;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       val_in;
  logic       pg_src;
  logic       pg_bypass;
  logic       pg_in;
  logic       pg_tog;
  logic [6:0] hw_a, hw_b;
  logic       vo_a, vo_b;

  int n_assert = 0;
  int n_fail   = 0;

  // Default configuration.
  tdc_mux_delay_core #(.N(64), .DL_TYPE("DMUX"), .N_SYNC(1), .POP_METHOD("SV")) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .val_in_i(val_in),
    .pg_src_i(pg_src), .pg_bypass_i(pg_bypass), .pg_in_i(pg_in), .pg_tog_i(pg_tog),
    .hw_o(hw_a), .val_out_o(vo_a)
  );

  // Alternate element/popcount style; must produce the same stream.
  tdc_mux_delay_core #(.N(64), .DL_TYPE("BUF"), .N_SYNC(1), .POP_METHOD("TREE")) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .val_in_i(val_in),
    .pg_src_i(pg_src), .pg_bypass_i(pg_bypass), .pg_in_i(pg_in), .pg_tog_i(pg_tog),
    .hw_o(hw_b), .val_out_o(vo_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Check both DUTs against the same expected hw/valid.
  task automatic chk(input string tag, input int exp_hw, input logic exp_vld);
    check({tag, " hw_a"},  {25'd0, hw_a}, exp_hw);
    check({tag, " vld_a"}, {31'd0, vo_a}, {31'd0, exp_vld});
    check({tag, " hw_b"},  {25'd0, hw_b}, exp_hw);
    check({tag, " vld_b"}, {31'd0, vo_b}, {31'd0, exp_vld});
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- Reset with random inputs ----------------
    rst_n     = 1'b0;
    en        = 1'($urandom_range(0, 1));
    val_in    = 1'($urandom_range(0, 1));
    pg_src    = 1'($urandom_range(0, 1));
    pg_bypass = 1'($urandom_range(0, 1));
    pg_in     = 1'($urandom_range(0, 1));
    pg_tog    = 1'($urandom_range(0, 1));
    #2;
    chk("reset_async", 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      en     = 1'($urandom_range(0, 1));
      pg_in  = 1'($urandom_range(0, 1));
      val_in = 1'($urandom_range(0, 1));
      chk("reset_held", 0, 1'b0);
    end

    // ---------------- Static high, single-cycle valid ----------------
    en = 1'b1; pg_src = 1'b0; pg_bypass = 1'b1; pg_in = 1'b1; val_in = 1'b0; pg_tog = 1'b0;
    #2 rst_n = 1'b1;
    val_in = 1'b1;
    tick();                 // edge k: capture
    val_in = 1'b0;
    chk("high_k", 0, 1'b0);
    tick();                 // edge k+1: sync
    chk("high_k1", 0, 1'b0);
    tick();                 // edge k+2: output
    chk("high_k2", 64, 1'b1);
    tick();
    chk("high_k3", 64, 1'b0);

    // ---------------- Static low / disabled ----------------
    pg_in = 1'b0;
    repeat (3) tick();
    chk("low", 0, 1'b0);
    en = 1'b0; pg_in = 1'b1;
    repeat (3) tick();
    chk("disabled", 0, 1'b0);
    en = 1'b1;
    tick();
    tick();
    chk("enable_e2", 0, 1'b0);
    tick();
    chk("enable_e3", 64, 1'b0);

    // ---------------- Toggle source ----------------
    rst_n = 1'b0;
    pg_src = 1'b1; pg_bypass = 1'b1; en = 1'b1; pg_tog = 1'b1; pg_in = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e >= 3) chk($sformatf("tog_e%0d", e), (e % 2 == 0) ? 64 : 0, 1'b0);
    end
    pg_tog = 1'b0;          // tog_q frozen at 1
    tick(); chk("tog_hold_e8", 64, 1'b0);
    tick(); chk("tog_hold_e9", 0, 1'b0);
    for (int e = 10; e <= 12; e++) begin
      tick();
      chk($sformatf("tog_hold_e%0d", e), 64, 1'b0);
    end

    // ---------------- Pulse generator, zero delay ----------------
    pg_src = 1'b0; pg_bypass = 1'b0; pg_in = 1'b1;
    repeat (3) tick();
    chk("pulse_static", 0, 1'b0);
    pg_in = 1'b0; tick();
    pg_in = 1'b1; tick();
    tick(); tick();
    chk("pulse_edge", 0, 1'b0);

    // ---------------- Reset mid-stream ----------------
    pg_bypass = 1'b1; pg_in = 1'b1; val_in = 1'b1;
    repeat (4) tick();
    chk("mid_full", 64, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset", 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); chk("mid_rel_e1", 0, 1'b0);
    tick(); chk("mid_rel_e2", 0, 1'b0);
    tick(); chk("mid_rel_e3", 64, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
